// File: rtl/ospi_tx_seq.sv
// Octal-SPI DDR transmit sequencer: CMD, 2-cycle ADDR, LAT dummies, then WDATA or RDATA, then CS hold.
// Latency: outputs are registered, so CMD appears on the cycle after request acceptance.
// Backpressure: req_ready_o only in IDLE; a write-data stall (wd_valid_i low) freezes dp_o/dn_o and the word count.
// Build option: define OSPI_SEQ_CMD_INV_EN to send ~cmd on the falling half of the CMD cycle instead of cmd.
module ospi_tx_seq #(
  parameter int LEN_W   = 8,
  parameter int LAT_W   = 5,
  parameter int CS_HOLD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       req_cmd_i,
  input  logic [31:0]      req_addr_i,
  input  logic             req_we_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [LAT_W-1:0] req_lat_i,
  input  logic             wd_valid_i,
  output logic             wd_ready_o,
  input  logic [15:0]      wd_data_i,
  output logic [7:0]       dp_o,
  output logic [7:0]       dn_o,
  output logic             oe_o,
  output logic             cs_n_o,
  output logic             rd_en_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, LAT, WDATA, RDATA, HOLD
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(CS_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;      // data words still to go, minus one
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic             addr_ph_q, addr_ph_d;
  logic [7:0]       dp_q, dp_d, dn_q, dn_d;
  logic             oe_q, oe_d, cs_n_q, cs_n_d, rd_en_q, rd_en_d, wd_ready_q, wd_ready_d;
  logic             req_fire, wd_fire;

  // Second command byte for the falling half of the CMD cycle.
  function automatic logic [7:0] cmd_lo(input logic [7:0] c);
`ifdef OSPI_SEQ_CMD_INV_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  assign req_ready_o = (state_q == IDLE) && !reset;
  assign busy_o      = (state_q != IDLE) && !reset;
  assign req_fire    = req_valid_i && req_ready_o;
  // wd_ready_q is raised one cycle before the first data cycle so the first word lands without a bubble.
  assign wd_fire     = wd_valid_i && wd_ready_q;

  assign dp_o       = dp_q;
  assign dn_o       = dn_q;
  assign oe_o       = oe_q;
  assign cs_n_o     = cs_n_q;
  assign rd_en_o    = rd_en_q;
  assign wd_ready_o = wd_ready_q;

  // State and output registers; reset aborts any transaction without a hold phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      lat_q      <= '0;
      lat_cnt_q  <= '0;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      addr_ph_q  <= 1'b0;
      dp_q       <= '0;
      dn_q       <= '0;
      oe_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_en_q    <= 1'b0;
      wd_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      lat_q      <= lat_d;
      lat_cnt_q  <= lat_cnt_d;
      cnt_q      <= cnt_d;
      hold_cnt_q <= hold_cnt_d;
      addr_ph_q  <= addr_ph_d;
      dp_q       <= dp_d;
      dn_q       <= dn_d;
      oe_q       <= oe_d;
      cs_n_q     <= cs_n_d;
      rd_en_q    <= rd_en_d;
      wd_ready_q <= wd_ready_d;
    end
  end

  // Next state and next registered outputs; outputs are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    we_d       = we_q;
    lat_d      = lat_q;
    lat_cnt_d  = lat_cnt_q;
    cnt_d      = cnt_q;
    hold_cnt_d = hold_cnt_q;
    addr_ph_d  = addr_ph_q;
    dp_d       = dp_q;
    dn_d       = dn_q;
    oe_d       = oe_q;
    cs_n_d     = cs_n_q;
    rd_en_d    = rd_en_q;
    wd_ready_d = wd_ready_q;

    case (state_q)
      IDLE: begin
        cs_n_d     = 1'b1;
        oe_d       = 1'b0;
        dp_d       = '0;
        dn_d       = '0;
        rd_en_d    = 1'b0;
        wd_ready_d = 1'b0;
        if (req_fire) begin
          cmd_d   = req_cmd_i;
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          lat_d   = req_lat_i;
          cnt_d   = req_len_i;
          state_d = CMD;
          cs_n_d  = 1'b0;
          oe_d    = 1'b1;
          dp_d    = req_cmd_i;
          dn_d    = cmd_lo(req_cmd_i);
        end
      end
      CMD: begin
        state_d   = ADDR;
        addr_ph_d = 1'b0;
        dp_d      = addr_q[31:24];
        dn_d      = addr_q[23:16];
      end
      ADDR: begin
        if (!addr_ph_q) begin
          addr_ph_d  = 1'b1;
          dp_d       = addr_q[15:8];
          dn_d       = addr_q[7:0];
          wd_ready_d = we_q && (lat_q == '0);
        end else if (lat_q != '0) begin
          state_d    = LAT;
          lat_cnt_d  = lat_q - LAT_W'(1);
          dp_d       = '0;
          dn_d       = '0;
          oe_d       = we_q;
          wd_ready_d = we_q && (lat_q == LAT_W'(1));
        end else if (we_q) begin
          state_d = WDATA;
        end else begin
          state_d = RDATA;
          oe_d    = 1'b0;
          rd_en_d = 1'b1;
          dp_d    = '0;
          dn_d    = '0;
        end
      end
      LAT: begin
        if (lat_cnt_q == '0) begin
          if (we_q) begin
            state_d = WDATA;
          end else begin
            state_d = RDATA;
            rd_en_d = 1'b1;
          end
        end else begin
          lat_cnt_d  = lat_cnt_q - LAT_W'(1);
          wd_ready_d = we_q && (lat_cnt_q == LAT_W'(1));
        end
      end
      WDATA: begin
        // Ready low here means the last word is on the pins this cycle.
        if (!wd_ready_q) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_INIT;
          cs_n_d     = 1'b1;
          oe_d       = 1'b0;
          dp_d       = '0;
          dn_d       = '0;
        end
      end
      RDATA: begin
        if (cnt_q == '0) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_INIT;
          cs_n_d     = 1'b1;
          rd_en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Write-data handshake: load the word for the next cycle and count it down.
    if (wd_fire) begin
      dp_d = wd_data_i[15:8];
      dn_d = wd_data_i[7:0];
      if (cnt_q == '0) begin
        wd_ready_d = 1'b0;
      end else begin
        cnt_d      = cnt_q - LEN_W'(1);
        wd_ready_d = 1'b1;
      end
    end
  end

endmodule
